// File: rtl/comparator_pkg.sv
// Shared definitions for the branch comparator: op encodings, default width, flag bundle.
// Imported by com_mag_cmp and comparator.
package comparator_pkg;

    localparam int COM_DATA_WIDTH_DEF = 32;

    localparam logic [2:0] COM_OP_BEQ  = 3'd0;
    localparam logic [2:0] COM_OP_BNE  = 3'd1;
    localparam logic [2:0] COM_OP_BLEZ = 3'd2;
    localparam logic [2:0] COM_OP_BGTZ = 3'd3;
    localparam logic [2:0] COM_OP_BLTZ = 3'd4;
    localparam logic [2:0] COM_OP_BGEZ = 3'd5;
    localparam logic [2:0] COM_OP_BLTU = 3'd6;
    localparam logic [2:0] COM_OP_BGEU = 3'd7;

    typedef struct packed {
        logic igual;
        logic menor_s;
        logic menor_u;
    } com_flags_t;

    function automatic logic sign_of(input logic msb);
        return msb;
    endfunction

endpackage

// File: rtl/com_mag_cmp.sv
// Equality plus signed/unsigned less-than for one operand pair; purely combinational,
// zero latency, no flow control.
module com_mag_cmp
    import comparator_pkg::*;
#(
    parameter int DATA_WIDTH = COM_DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output com_flags_t            flags
);

    logic sign_a;
    logic sign_b;
    logic lt_u;

    assign sign_a = sign_of(a[DATA_WIDTH-1]);
    assign sign_b = sign_of(b[DATA_WIDTH-1]);
    assign lt_u   = (a < b);

    // With differing signs the negative operand is smaller; with equal signs
    // the two's-complement order matches the unsigned order.
    assign flags.igual   = (a == b);
    assign flags.menor_u = lt_u;
    assign flags.menor_s = (sign_a ^ sign_b) ? sign_a : lt_u;

endmodule

// File: rtl/comparator.sv
// Branch-condition comparator; TOMAR/VALID are combinational by default, or registered
// with one cycle of latency when COM_REG_OUT_EN is defined. No backpressure.
module comparator
    import comparator_pkg::*;
#(
    parameter int DATA_WIDTH = COM_DATA_WIDTH_DEF
) (
    input  logic                  I_COM_CLK,
    input  logic                  I_COM_RST,
    input  logic [DATA_WIDTH-1:0] I_COM_A,
    input  logic [DATA_WIDTH-1:0] I_COM_B,
    input  logic [2:0]            I_COM_OP,
    input  logic                  I_COM_VALID,
    output logic                  O_COM_IGUAL,
    output logic                  O_COM_MENOR_S,
    output logic                  O_COM_MENOR_U,
    output logic                  O_COM_TOMAR,
    output logic                  O_COM_VALID
);

    com_flags_t flags;
    logic       a_neg;
    logic       a_zero;
    logic       cond;

    com_mag_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mag_cmp (
        .a     (I_COM_A),
        .b     (I_COM_B),
        .flags (flags)
    );

    assign O_COM_IGUAL   = flags.igual;
    assign O_COM_MENOR_S = flags.menor_s;
    assign O_COM_MENOR_U = flags.menor_u;

    assign a_neg  = sign_of(I_COM_A[DATA_WIDTH-1]);
    assign a_zero = (I_COM_A == '0);

    always_comb begin
        cond = 1'b0;
        case (I_COM_OP)
            COM_OP_BEQ:  cond = flags.igual;
            COM_OP_BNE:  cond = !flags.igual;
            COM_OP_BLEZ: cond = a_neg || a_zero;
            COM_OP_BGTZ: cond = !a_neg && !a_zero;
            COM_OP_BLTZ: cond = a_neg;
            COM_OP_BGEZ: cond = !a_neg;
            COM_OP_BLTU: cond = flags.menor_u;
            COM_OP_BGEU: cond = !flags.menor_u;
            default:     cond = 1'b0;
        endcase
    end

`ifdef COM_REG_OUT_EN
    logic tomar_q;
    logic valid_q;

    always_ff @(posedge I_COM_CLK or posedge I_COM_RST) begin
        if (I_COM_RST) begin
            tomar_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            tomar_q <= cond & I_COM_VALID;
            valid_q <= I_COM_VALID;
        end
    end

    assign O_COM_TOMAR = tomar_q;
    assign O_COM_VALID = valid_q;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = I_COM_CLK ^ I_COM_RST;
    assign O_COM_TOMAR    = cond & I_COM_VALID;
    assign O_COM_VALID    = I_COM_VALID;
`endif

endmodule

// File: tb/tb_comparator.sv
// Directed self-checking bench for comparator; adapts its timing to COM_REG_OUT_EN.
module tb_comparator;
    import comparator_pkg::*;

    localparam int W = 32;
`ifdef COM_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [2:0]   op  = COM_OP_BEQ;
    logic         vin = 1'b0;
    logic         igual, menor_s, menor_u, tomar, vout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    comparator #(.DATA_WIDTH(W)) dut (
        .I_COM_CLK     (clk),
        .I_COM_RST     (rst),
        .I_COM_A       (a),
        .I_COM_B       (b),
        .I_COM_OP      (op),
        .I_COM_VALID   (vin),
        .O_COM_IGUAL   (igual),
        .O_COM_MENOR_S (menor_s),
        .O_COM_MENOR_U (menor_u),
        .O_COM_TOMAR   (tomar),
        .O_COM_VALID   (vout)
    );

    // Drive at the falling edge; in registered mode wait for the capturing edge.
    task automatic apply(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2:0] vop, input logic vv);
        @(negedge clk);
        a = va; b = vb; op = vop; vin = vv;
        if (REG_OUT) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a = 32'd5; b = 32'd5; op = COM_OP_BEQ; vin = 1'b1;
        #1 rst = 1'b1;
        #2;
        n_cmp++; if (tomar !== (REG_OUT ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL reset_tomar: got %b want %b", tomar, !REG_OUT); end
        n_cmp++; if (vout !== (REG_OUT ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL reset_valid: got %b want %b", vout, !REG_OUT); end
        n_cmp++; if (igual !== 1'b1) begin n_err++; $display("FAIL reset_igual: got %b want 1", igual); end
        @(posedge clk); #1;
        n_cmp++; if (tomar !== (REG_OUT ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL reset_held_tomar: got %b want %b", tomar, !REG_OUT); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (tomar !== 1'b1) begin n_err++; $display("FAIL first_capture_tomar: got %b want 1", tomar); end
        n_cmp++; if (vout !== 1'b1) begin n_err++; $display("FAIL first_capture_valid: got %b want 1", vout); end
    endtask

    task automatic test_equality;
        apply(32'd0, 32'd0, COM_OP_BEQ, 1'b1);
        n_cmp++; if (igual !== 1'b1) begin n_err++; $display("FAIL eq_0_0: got %b want 1", igual); end
        n_cmp++; if (tomar !== 1'b1) begin n_err++; $display("FAIL beq_0_0: got %b want 1", tomar); end
        apply(32'd255, 32'd0, COM_OP_BEQ, 1'b1);
        n_cmp++; if (igual !== 1'b0) begin n_err++; $display("FAIL eq_255_0: got %b want 0", igual); end
        n_cmp++; if (tomar !== 1'b0) begin n_err++; $display("FAIL beq_255_0: got %b want 0", tomar); end
        apply(32'd255, 32'd255, COM_OP_BNE, 1'b1);
        n_cmp++; if (igual !== 1'b1) begin n_err++; $display("FAIL eq_255_255: got %b want 1", igual); end
        n_cmp++; if (tomar !== 1'b0) begin n_err++; $display("FAIL bne_255_255: got %b want 0", tomar); end
        apply(32'h00AA1155, 32'h00AA1155, COM_OP_BEQ, 1'b1);
        n_cmp++; if (igual !== 1'b1) begin n_err++; $display("FAIL eq_aa1155: got %b want 1", igual); end
        apply(32'h0000FF3C, 32'hFFFFFFFF, COM_OP_BNE, 1'b1);
        n_cmp++; if (igual !== 1'b0) begin n_err++; $display("FAIL eq_ff3c_ones: got %b want 0", igual); end
        n_cmp++; if (menor_u !== 1'b1) begin n_err++; $display("FAIL ltu_ff3c_ones: got %b want 1", menor_u); end
        n_cmp++; if (menor_s !== 1'b0) begin n_err++; $display("FAIL lts_ff3c_ones: got %b want 0", menor_s); end
        n_cmp++; if (tomar !== 1'b1) begin n_err++; $display("FAIL bne_ff3c_ones: got %b want 1", tomar); end
        apply(32'h0000FF3C, 32'h0000FF3C, COM_OP_BEQ, 1'b1);
        n_cmp++; if (igual !== 1'b1) begin n_err++; $display("FAIL eq_ff3c: got %b want 1", igual); end
        apply(32'h80000000, 32'h00000000, COM_OP_BEQ, 1'b1);
        n_cmp++; if (igual !== 1'b0) begin n_err++; $display("FAIL eq_msb_only: got %b want 0", igual); end
    endtask

    task automatic test_zero_ops;
        logic [2:0] ops [4];
        logic       exp_neg [4];
        logic       exp_zero [4];
        logic       exp_pos [4];
        ops      = '{COM_OP_BLEZ, COM_OP_BLTZ, COM_OP_BGTZ, COM_OP_BGEZ};
        exp_neg  = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_zero = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_pos  = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply(32'h80000000, 32'h80000000, ops[i], 1'b1);
            n_cmp++; if (tomar !== exp_neg[i]) begin n_err++; $display("FAIL zero_op_neg op=%0d: got %b want %b", ops[i], tomar, exp_neg[i]); end
            apply(32'h00000000, 32'hFFFFFFFF, ops[i], 1'b1);
            n_cmp++; if (tomar !== exp_zero[i]) begin n_err++; $display("FAIL zero_op_zero op=%0d: got %b want %b", ops[i], tomar, exp_zero[i]); end
            apply(32'h00000001, 32'h00000000, ops[i], 1'b1);
            n_cmp++; if (tomar !== exp_pos[i]) begin n_err++; $display("FAIL zero_op_pos op=%0d: got %b want %b", ops[i], tomar, exp_pos[i]); end
        end
    endtask

    task automatic test_unsigned_ops;
        apply(32'd1, 32'hFFFFFFFF, COM_OP_BLTU, 1'b1);
        n_cmp++; if (tomar !== 1'b1) begin n_err++; $display("FAIL bltu_1_ones: got %b want 1", tomar); end
        n_cmp++; if (menor_s !== 1'b0) begin n_err++; $display("FAIL lts_1_ones: got %b want 0", menor_s); end
        apply(32'd1, 32'hFFFFFFFF, COM_OP_BGEU, 1'b1);
        n_cmp++; if (tomar !== 1'b0) begin n_err++; $display("FAIL bgeu_1_ones: got %b want 0", tomar); end
        apply(32'h1234, 32'h1234, COM_OP_BLTU, 1'b1);
        n_cmp++; if (tomar !== 1'b0) begin n_err++; $display("FAIL bltu_equal: got %b want 0", tomar); end
        apply(32'h1234, 32'h1234, COM_OP_BGEU, 1'b1);
        n_cmp++; if (tomar !== 1'b1) begin n_err++; $display("FAIL bgeu_equal: got %b want 1", tomar); end
    endtask

    task automatic test_signed;
        apply(32'hFFFFFFFF, 32'd1, COM_OP_BEQ, 1'b1);
        n_cmp++; if (menor_s !== 1'b1) begin n_err++; $display("FAIL lts_m1_1: got %b want 1", menor_s); end
        n_cmp++; if (menor_u !== 1'b0) begin n_err++; $display("FAIL ltu_m1_1: got %b want 0", menor_u); end
        apply(32'h80000000, 32'h7FFFFFFF, COM_OP_BEQ, 1'b1);
        n_cmp++; if (menor_s !== 1'b1) begin n_err++; $display("FAIL lts_min_max: got %b want 1", menor_s); end
        n_cmp++; if (menor_u !== 1'b0) begin n_err++; $display("FAIL ltu_min_max: got %b want 0", menor_u); end
        apply(32'hFFFFFFFE, 32'hFFFFFFFF, COM_OP_BEQ, 1'b1);
        n_cmp++; if (menor_s !== 1'b1) begin n_err++; $display("FAIL lts_m2_m1: got %b want 1", menor_s); end
        apply(32'd7, 32'd7, COM_OP_BEQ, 1'b1);
        n_cmp++; if (menor_s !== 1'b0) begin n_err++; $display("FAIL lts_equal: got %b want 0", menor_s); end
    endtask

    task automatic test_valid_gate;
        apply(32'd9, 32'd9, COM_OP_BEQ, 1'b0);
        n_cmp++; if (tomar !== 1'b0) begin n_err++; $display("FAIL gate_tomar: got %b want 0", tomar); end
        n_cmp++; if (vout !== 1'b0) begin n_err++; $display("FAIL gate_valid: got %b want 0", vout); end
        n_cmp++; if (igual !== 1'b1) begin n_err++; $display("FAIL gate_igual: got %b want 1", igual); end
    endtask

    task automatic test_valid_pulse;
        @(negedge clk);
        a = 32'hCAFE; b = 32'hCAFE; op = COM_OP_BEQ; vin = 1'b1;
        #1;
        n_cmp++; if (vout !== (REG_OUT ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL pulse_pre_valid: got %b want %b", vout, !REG_OUT); end
        n_cmp++; if (tomar !== (REG_OUT ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL pulse_pre_tomar: got %b want %b", tomar, !REG_OUT); end
        @(posedge clk); #1;
        n_cmp++; if (tomar !== 1'b1) begin n_err++; $display("FAIL pulse_tomar: got %b want 1", tomar); end
        n_cmp++; if (vout !== 1'b1) begin n_err++; $display("FAIL pulse_valid: got %b want 1", vout); end
        @(negedge clk); vin = 1'b0;
        #1;
        n_cmp++; if (vout !== (REG_OUT ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL pulse_hold_valid: got %b want %b", vout, REG_OUT); end
        @(posedge clk); #1;
        n_cmp++; if (tomar !== 1'b0) begin n_err++; $display("FAIL pulse_end_tomar: got %b want 0", tomar); end
        n_cmp++; if (vout !== 1'b0) begin n_err++; $display("FAIL pulse_end_valid: got %b want 0", vout); end
    endtask

    task automatic test_back_to_back;
        apply(32'd3, 32'd4, COM_OP_BLTU, 1'b1);
        n_cmp++; if (tomar !== 1'b1) begin n_err++; $display("FAIL b2b_0: got %b want 1", tomar); end
        apply(32'd3, 32'd4, COM_OP_BEQ, 1'b1);
        n_cmp++; if (tomar !== 1'b0) begin n_err++; $display("FAIL b2b_1: got %b want 0", tomar); end
        apply(32'd4, 32'd4, COM_OP_BGEU, 1'b1);
        n_cmp++; if (tomar !== 1'b1) begin n_err++; $display("FAIL b2b_2: got %b want 1", tomar); end
    endtask

    task automatic test_reset_mid_op;
        apply(32'h55, 32'h55, COM_OP_BEQ, 1'b1);
        n_cmp++; if (tomar !== 1'b1) begin n_err++; $display("FAIL mid_pre_tomar: got %b want 1", tomar); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tomar !== (REG_OUT ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL mid_rst_tomar: got %b want %b", tomar, !REG_OUT); end
        n_cmp++; if (vout !== (REG_OUT ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL mid_rst_valid: got %b want %b", vout, !REG_OUT); end
        n_cmp++; if (igual !== 1'b1) begin n_err++; $display("FAIL mid_rst_igual: got %b want 1", igual); end
        b = 32'h56;
        #1;
        n_cmp++; if (igual !== 1'b0) begin n_err++; $display("FAIL mid_rst_igual_track: got %b want 0", igual); end
        n_cmp++; if (menor_u !== 1'b1) begin n_err++; $display("FAIL mid_rst_ltu_track: got %b want 1", menor_u); end
        @(negedge clk); rst = 1'b0; vin = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_equality();
        test_zero_ops();
        test_unsigned_ops();
        test_signed();
        test_valid_gate();
        test_valid_pulse();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
